// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the pipeline and the multiply/divide unit
interface muldiv_if;

  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  op;
  logic        start;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output A, B, op, start, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  A, B, op, start, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply / 32/32 divide with HI/LO registers
// One bit per cycle on a shared 64-bit shift register; signs are stripped at start and restored at FIN.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               in_signed;
  logic               in_div;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;

  logic [32:0]        mul_sum;
  logic [63:0]        mul_step;
  logic [32:0]        div_top;
  logic               div_ge;
  logic [31:0]        div_diff;
  logic [63:0]        div_step;

  logic [63:0]        prod_fix;
  logic [31:0]        quot_fix;
  logic [31:0]        rem_fix;

  assign in_signed = op_is_signed(bus.op);
  assign in_div    = op_is_div(bus.op);
  assign a_neg     = in_signed & bus.A[31];
  assign b_neg     = in_signed & bus.B[31];
  assign a_mag     = mag32(bus.A, a_neg);
  assign b_mag     = mag32(bus.B, b_neg);

  // Multiply: conditional add into the upper half, then shift the whole register right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};

  // Restoring divide: partial remainder lives in the upper half, quotient bits shift in at the bottom.
  assign div_top  = acc_q[63:31];
  assign div_ge   = (div_top >= {1'b0, opnd_q});
  assign div_diff = div_top[31:0] - opnd_q;
  assign div_step = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};

  assign prod_fix = neg_q  ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = mag32(acc_q[31:0], neg_q);
  assign rem_fix  = mag32(acc_q[63:32], rneg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CALC;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = in_div;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          div0_d   = in_div && (bus.B == 32'd0);
          opnd_d   = in_div ? b_mag : a_mag;
          acc_d    = {32'd0, in_div ? a_mag : b_mag};
        end else begin
          if (bus.mthi) hi_d = bus.A;
          if (bus.mtlo) lo_d = bus.A;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? 32'hFFFF_FFFF : quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  muldiv_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one op; edge #1 is the start edge. Optionally injects start/mthi/mtlo after edge inj.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output int d_edge, output int b_cnt, output int hold_bad);
    logic [31:0] h0;
    logic [31:0] l0;
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.op = op; bus.A = a; bus.B = b;
    bus.start = 1'b1; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    d_edge = 0; b_cnt = 0; hold_bad = 0; r_hi = '0; r_lo = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) b_cnt++;
      if (bus.done) begin
        d_edge = n;
        r_hi = bus.hi;
        r_lo = bus.lo;
        break;
      end else if (bus.hi !== h0 || bus.lo !== l0) begin
        hold_bad++;
      end
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      bus.A = $urandom; bus.B = $urandom;
      if (n == inj) begin
        bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        bus.op = OP_DIVU; bus.A = 32'hDEADBEEF;
      end
    end
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
  endtask

  logic [31:0] r_hi, r_lo, h_prev, l_prev;
  int d_edge, b_cnt, hold_bad, done_seen, busy_seen;

  initial begin
    tests = 0; fails = 0;
    bus.A = '0; bus.B = '0; bus.op = OP_MULT;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[7]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
    vecs[9]  = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    rst_n = 1'b0;
    #12;
    check32("reset_hi", bus.hi, 32'h0);
    check32("reset_lo", bus.lo, 32'h0);
    check32("reset_busy", {31'd0, bus.busy}, 32'h0);
    check32("reset_done", {31'd0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r_hi, r_lo, d_edge, b_cnt, hold_bad);
      check32($sformatf("vec%0d_hi", i), r_hi, vecs[i].exp_hi);
      check32($sformatf("vec%0d_lo", i), r_lo, vecs[i].exp_lo);
      check_int($sformatf("vec%0d_done_edge", i), d_edge, 34);
      check_int($sformatf("vec%0d_busy_cycles", i), b_cnt, 33);
      check_int($sformatf("vec%0d_hilo_hold", i), hold_bad, 0);
    end

    // Idle mthi/mtlo writes
    @(negedge clk);
    bus.A = 32'h0000ABCD; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0;
    check32("mthi_hi", bus.hi, 32'h0000ABCD);
    bus.A = 32'h00005678; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check32("mtlo_lo", bus.lo, 32'h00005678);
    check32("mtlo_hi_kept", bus.hi, 32'h0000ABCD);

    // start wins over mthi/mtlo in the same cycle
    @(negedge clk);
    bus.op = OP_MULTU; bus.A = 32'h00000005; bus.B = 32'h00000003;
    bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check32("start_prio_hi", bus.hi, 32'h0000ABCD);
    check32("start_prio_lo", bus.lo, 32'h00005678);
    check32("start_prio_busy", {31'd0, bus.busy}, 32'h1);
    done_seen = 0;
    for (int n = 0; n < 50 && done_seen == 0; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_seen = 1;
        check32("start_prio_res_hi", bus.hi, 32'h0);
        check32("start_prio_res_lo", bus.lo, 32'h0000000F);
      end
    end
    check_int("start_prio_done", done_seen, 1);

    // Second start plus mthi/mtlo during CALC must be ignored
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, r_hi, r_lo, d_edge, b_cnt, hold_bad);
    check32("midcalc_hi", r_hi, 32'hFFFFFFFE);
    check32("midcalc_lo", r_lo, 32'h00000001);
    check_int("midcalc_done_edge", d_edge, 34);
    check_int("midcalc_hold", hold_bad, 0);
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.done) busy_seen++;
    end
    check_int("midcalc_no_queue", busy_seen, 0);
    bus.A = 32'h00001234; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0;
    check32("idle_mthi_1234", bus.hi, 32'h00001234);

    // Reset at CALC cycle 10 aborts the op
    bus.op = OP_MULTU; bus.A = 32'h00000009; bus.B = 32'h00000009; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("abort_hi", bus.hi, 32'h0);
    check32("abort_lo", bus.lo, 32'h0);
    check32("abort_busy", {31'd0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    check_int("abort_no_done", done_seen, 0);
    check_int("abort_no_busy", busy_seen, 0);
    check32("abort_hi_after", bus.hi, 32'h0);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 0, r_hi, r_lo, d_edge, b_cnt, hold_bad);
    check32("after_abort_hi", r_hi, 32'hFFFFFFFF);
    check32("after_abort_lo", r_lo, 32'hFFFFFFF1);
    check_int("after_abort_done_edge", d_edge, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 32 bits, matching the ALU operand buses.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 A  input  32  operand 1: multiplicand/dividend, and write data for mthi/mtlo.
REQ-005 B  input  32  operand 2: multiplier/divisor.
REQ-006 op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 start  input  1  single-cycle request to begin op on A/B.
REQ-008 mthi  input  1  write A into HI.
REQ-009 mtlo  input  1  write A into LO.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-012 hi  output  32  HI register (product upper word / remainder).
REQ-013 lo  output  32  LO register (product lower word / quotient).

Function
REQ-014 FSM states SHALL be IDLE, CALC and FIN; IDLE->CALC on start while idle, CALC->FIN after 32 iterations, FIN->IDLE unconditionally.
REQ-015 At the start edge, the unit SHALL latch op, sign flags and operand magnitudes (absolute values for signed ops, raw values for unsigned), clear the 5-bit iteration counter and set busy.
REQ-016 CALC SHALL run exactly 32 cycles: shift-add for multiply (64-bit accumulator), restoring shift-subtract for divide, one bit per cycle.
REQ-017 FIN SHALL apply sign correction and write HI/LO at the same edge, pulse done for the following cycle and clear busy at that edge.
REQ-018 Latency: done SHALL be high in the cycle 34 edges after the start edge; busy SHALL be high for exactly 33 cycles.
REQ-019 mult: {hi,lo} SHALL be the 64-bit two's-complement product; multu: the unsigned product.
REQ-020 div: lo SHALL be the quotient truncated toward zero, and hi SHALL be the remainder carrying the dividend's sign.
REQ-021 divu: lo SHALL be the unsigned quotient and hi the unsigned remainder.
REQ-022 Divide by zero SHALL take the full latency with no exception: lo=32'hFFFFFFFF, hi=A.
REQ-023 Signed div 32'h80000000/32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-024 start, mthi and mtlo SHALL be ignored while busy; no queuing.
REQ-025 In IDLE, mthi/mtlo SHALL write A to HI/LO at the next edge; start SHALL take priority over mthi/mtlo in the same cycle, and the writes are dropped.
REQ-026 hi/lo SHALL hold their values during CALC and change only at FIN or on mthi/mtlo.
REQ-027 A and B need not be held stable after the start edge.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and accumulators=0.
REQ-029 Reset during CALC/FIN SHALL abort the operation; no done pulse and no HI/LO write after release.
REQ-030 The first start after reset release SHALL be accepted at the first rising edge.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum and ITER=32.
REQ-032 The block SHALL be a single module with no sub-module; the shared 64-bit shift register serves both multiply and divide.

Verification
REQ-033 multu A=FFFFFFFF B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 34 edges after start; busy 33 cycles.
REQ-034 mult A=FFFFFFFD(-3) B=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; div A=FFFFFFF9(-7) B=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-035 divu A=7 B=0 -> lo=FFFFFFFF, hi=7; div A=80000000 B=FFFFFFFF -> lo=80000000, hi=0.
REQ-036 Second start plus mthi pulsed mid-CALC -> ignored; the first result is delivered, then idle mthi A=1234 -> hi=1234 at the next edge.
REQ-037 rst_n pulsed low at CALC cycle 10 -> hi=lo=0, busy=0, no done pulse; a new start then completes normally.
